ps2_host_sender: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3 and so on) to the keyboard over the shared open-drain PS2_CLK/PS2_DAT lines. It sits beside the keyboard receiver and drives the lines low through external open-drain buffers. While busy, the receiver ignores line activity.

---
 rtl/ps2_host_sender.sv | 185 ++++++++++++++++++
 tb/tb_ps2_host_sender.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_sender.sv
// PS/2 host-to-device command transmitter: inhibits the device clock, issues a
// start bit, then shifts the byte, odd parity and stop out on device clock falls.
module ps2_host_sender #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       device_clock,
   input  logic       device_data,
   input  logic [7:0] tx_data,
   input  logic       tx_request,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic       device_clock_drive,
   output logic       device_data_drive
);

   localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam bit SKIP_INH   = (INHIBIT_CYCLES <= 1);
   // START is the final clock-low cycle, so INHIBIT itself lasts one cycle less
   localparam logic [CNT_W-1:0] INHIBIT_LAST = SKIP_INH ? '0 : CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic             clk_prev_q, clk_prev_d;
   logic             clk_drive_q, clk_drive_d;
   logic             data_drive_q, data_drive_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             fall, wd_expired;

   always_comb begin
      fall         = clk_prev_q & ~device_clock;
      cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      wd_expired   = (cnt_q >= TIMEOUT_LAST);
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      clk_prev_d   = device_clock;
      clk_drive_d  = clk_drive_q;
      data_drive_d = data_drive_q;
      done_d       = 1'b0;
      error_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_request) begin
               state_d      = SKIP_INH ? START : INHIBIT;
               cnt_d        = '0;
               shift_d      = tx_data;
               parity_d     = ~^tx_data;
               clk_drive_d  = 1'b1;
               data_drive_d = SKIP_INH;
            end
         end
         INHIBIT: begin
            if (cnt_q >= INHIBIT_LAST) begin
               state_d      = START;
               data_drive_d = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         START: begin
            state_d     = SEND;
            clk_drive_d = 1'b0;
            bit_idx_d   = '0;
            cnt_d       = '0;
         end
         SEND: begin
            if (fall) begin
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q < 4'd8) begin
                  data_drive_d = ~shift_q[0];
                  shift_d      = {1'b0, shift_q[7:1]};
               end else if (bit_idx_q == 4'd8) begin
                  data_drive_d = ~parity_q;
               end else begin
                  data_drive_d = 1'b0;
                  state_d      = ACK;
               end
            end else if (wd_expired) begin
               state_d      = IDLE;
               clk_drive_d  = 1'b0;
               data_drive_d = 1'b0;
               error_d      = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ACK: begin
            if (fall) begin
               cnt_d = '0;
               if (!device_data) begin
                  state_d = WAIT_IDLE;
               end else begin
                  state_d = IDLE;
                  error_d = 1'b1;
               end
            end else if (wd_expired) begin
               state_d      = IDLE;
               clk_drive_d  = 1'b0;
               data_drive_d = 1'b0;
               error_d      = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_IDLE: begin
            // device has acknowledged; finish once it lets both lines float high
            if (device_clock && device_data) begin
               state_d = IDLE;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else if (fall) begin
               cnt_d = '0;
            end else if (wd_expired) begin
               state_d      = IDLE;
               clk_drive_d  = 1'b0;
               data_drive_d = 1'b0;
               error_d      = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d      = IDLE;
            clk_drive_d  = 1'b0;
            data_drive_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         clk_prev_q   <= 1'b1;
         clk_drive_q  <= 1'b0;
         data_drive_q <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         clk_prev_q   <= clk_prev_d;
         clk_drive_q  <= clk_drive_d;
         data_drive_q <= data_drive_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   always_ff @(posedge clock) begin
      shift_q  <= shift_d;
      parity_q <= parity_d;
   end

   assign tx_ready           = (state_q == IDLE);
   assign tx_busy            = ~tx_ready;
   assign tx_done            = done_q;
   assign tx_error           = error_q;
   assign device_clock_drive = clk_drive_q;
   assign device_data_drive  = data_drive_q;

endmodule

// File: tb/tb_ps2_host_sender.sv
// Bench for ps2_host_sender: open-drain line model, scripted keyboard, and a
// timestamp-based expectation model compared against the outputs every cycle.
module tb_ps2_host_sender;

   localparam int INH = 8;
   localparam int TMO = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_request = 1'b0;
   logic       tx_ready, tx_busy, tx_done, tx_error;
   logic       device_clock_drive, device_data_drive;
   logic       line_clk, line_dat;

   assign line_clk = dev_clk & ~device_clock_drive;
   assign line_dat = dev_dat & ~device_data_drive;

   ps2_host_sender #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clk),
      .reset(rst),
      .device_clock(line_clk),
      .device_data(line_dat),
      .tx_data(tx_data),
      .tx_request(tx_request),
      .tx_ready(tx_ready),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .tx_error(tx_error),
      .device_clock_drive(device_clock_drive),
      .device_data_drive(device_data_drive)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // expectation model state (written only by the compare process)
   int         n = 0;
   bit         m_busy = 1'b0;
   bit         waiting = 1'b0;
   int         t1 = 0, nf = 0, clr = 0, k = 0;
   logic [8:0] bits = '0;
   logic       e_ready = 1'b1, e_done = 1'b0, e_err = 1'b0, e_cd = 1'b0, e_dd = 1'b0;
   logic       prev_l = 1'b1, prev_busy = 1'b0, fall_m = 1'b0;
   logic [5:0] act_v, exp_v;
   int         starts = 0, done_cnt = 0, err_cnt = 0;

   // literal-check handshake from the stimulus process
   string lit_name = "";
   int    lit_got = 0, lit_exp = 0;
   int    lit_req = 0, lit_ack = 0;

   always @(negedge clk) begin
      act_v = {tx_ready, tx_busy, tx_done, tx_error, device_clock_drive, device_data_drive};
      exp_v = {e_ready, ~e_ready, e_done, e_err, e_cd, e_dd};
      vectors++;
      if (act_v !== exp_v) begin
         miscompares++;
         $display("FAIL cycle%0d {rdy,bsy,done,err,cdrv,ddrv}: got %b expected %b", n, act_v, exp_v);
      end
      if (lit_req != lit_ack) begin
         vectors++;
         if (lit_got != lit_exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", lit_name, lit_got, lit_exp);
         end
         lit_ack = lit_req;
      end
      if (tx_busy === 1'b1 && prev_busy === 1'b0) starts++;
      if (tx_done === 1'b1) done_cnt++;
      if (tx_error === 1'b1) err_cnt++;
      prev_busy = tx_busy;

      // predict the outputs that follow the next rising edge
      e_done = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (tx_request) begin
            m_busy  = 1'b1;
            t1      = n + 1;
            nf      = 0;
            clr     = t1 + INH;
            waiting = 1'b0;
            bits    = {($countones(tx_data) % 2 == 0), tx_data};
         end
      end else begin
         fall_m = (n >= t1 + INH) && prev_l && !line_clk;
         if (waiting) begin
            if (line_clk && line_dat) begin
               m_busy = 1'b0;
               e_done = 1'b1;
            end else if (fall_m) begin
               clr = n + 1;
            end
         end else if (fall_m) begin
            if (nf < 10) begin
               nf++;
               clr = n + 1;
            end else if (!line_dat) begin
               waiting = 1'b1;
               clr = n + 1;
            end else begin
               m_busy = 1'b0;
               e_err  = 1'b1;
            end
         end
         if (m_busy && (n + 1 - clr) >= TMO) begin
            m_busy = 1'b0;
            e_err  = 1'b1;
         end
      end
      k = n + 1 - t1;
      e_ready = !m_busy;
      e_cd = m_busy && (k < INH);
      e_dd = m_busy && ((k == INH - 1) ||
             ((k >= INH) && ((nf == 0) || ((nf < 10) && !bits[nf-1]))));
      prev_l = line_clk;
      n++;
   end

   task automatic lit_check(input string name, input int got, input int exp);
      lit_name = name;
      lit_got  = got;
      lit_exp  = exp;
      lit_req++;
      @(negedge clk);
      #1;
   endtask

   // keyboard: waits for request-to-send, then 11 clocks of 10 cycles each
   task automatic dev_xfer(input bit ack, input int rst_at, input bit drop_req,
                           output logic [9:0] samp, output int cd_cnt, output int both_cnt,
                           output bit ok);
      samp = '0; cd_cnt = 0; both_cnt = 0; ok = 1'b0;
      for (int w = 0; w < 100; w++) begin
         @(posedge clk); #2;
         if (drop_req) tx_request = 1'b0;
         if (device_clock_drive) cd_cnt++;
         if (device_clock_drive && device_data_drive) both_cnt++;
         if (!device_clock_drive && device_data_drive) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      repeat (4) @(posedge clk);
      #2;
      for (int i = 0; i < 11; i++) begin
         dev_clk = 1'b0;
         if (i == 10 && ack) dev_dat = 1'b0;
         if (i == rst_at) begin
            repeat (2) @(posedge clk);
            #2 rst = 1'b1;
            @(posedge clk);
            #2 rst = 1'b0;
            dev_clk = 1'b1;
            return;
         end
         repeat (5) @(posedge clk);
         #2 dev_clk = 1'b1;
         if (i < 10) samp[i] = line_dat;
         if (i == 10) dev_dat = 1'b1;
         repeat (5) @(posedge clk);
         #2;
      end
   endtask

   task automatic xfer(input logic [7:0] d, input bit ack, input logic [9:0] exp_samp, input bit hold);
      logic [9:0] samp;
      int cdc, bc, d0, e0;
      bit ok;
      d0 = done_cnt;
      e0 = err_cnt;
      @(posedge clk); #2;
      tx_data = d;
      tx_request = 1'b1;
      dev_xfer(ack, -1, !hold, samp, cdc, bc, ok);
      repeat (3) @(posedge clk);
      #2;
      lit_check("rts_seen", int'(ok), 1);
      lit_check("inhibit_len", cdc, INH);
      lit_check("start_overlap", bc, 1);
      lit_check("samples", int'(samp), int'(exp_samp));
      lit_check("done_pulses", done_cnt - d0, int'(ack));
      lit_check("error_pulses", err_cnt - e0, int'(!ack));
      if (!hold) lit_check("lines_released", int'({device_clock_drive, device_data_drive}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [9:0] samp;
      int cdc, bc, cnt, s0;
      bit ok;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      lit_check("reset_state", int'({tx_ready, tx_busy, tx_done, tx_error,
                device_clock_drive, device_data_drive}), 6'b100000);

      xfer(8'hED, 1'b1, 10'h3ED, 1'b0);
      xfer(8'h00, 1'b1, 10'h300, 1'b0);
      xfer(8'hFF, 1'b1, 10'h3FF, 1'b0);
      xfer(8'h07, 1'b0, 10'h207, 1'b0);

      // device never clocks: error a full watchdog period after release
      @(posedge clk); #2;
      tx_data = 8'h12;
      tx_request = 1'b1;
      @(posedge clk); #2;
      tx_request = 1'b0;
      for (int w = 0; w < 50; w++) begin
         if (!device_clock_drive && device_data_drive) break;
         @(posedge clk); #2;
      end
      cnt = 0;
      for (int w = 0; w < 200; w++) begin
         @(posedge clk); #2;
         cnt++;
         if (tx_error) break;
      end
      lit_check("timeout_cycles", cnt, TMO);
      lit_check("timeout_lines", int'({device_clock_drive, device_data_drive}), 0);

      // request held high through a transfer
      s0 = starts;
      xfer(8'h0F, 1'b1, 10'h30F, 1'b1);
      lit_check("held_starts", starts - s0, 2);
      tx_request = 1'b0;
      dev_xfer(1'b1, -1, 1'b0, samp, cdc, bc, ok);
      repeat (3) @(posedge clk);
      #2;
      lit_check("held_second_samples", int'(samp), 10'h30F);
      lit_check("held_starts_final", starts - s0, 2);

      // reset during the 4th data bit, then a clean transfer
      @(posedge clk); #2;
      tx_data = 8'hA5;
      tx_request = 1'b1;
      dev_xfer(1'b1, 3, 1'b1, samp, cdc, bc, ok);
      lit_check("reset_abort", int'({tx_ready, tx_busy, tx_done, tx_error,
                device_clock_drive, device_data_drive}), 6'b100000);
      xfer(8'hF3, 1'b1, 10'h3F3, 1'b0);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
